// File: rtl/processador_v3.sv
// Single-accumulator sequencer: loadable program memory, tick divider,
// run/step/halt control, conditional jumps and sticky signed overflow.
module processador_v3 #(
  parameter int DATA_W   = 15,
  parameter int ADDR_W   = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              CLK_50,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_chave,
  input  logic              run,
  input  logic              step,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W+3:0] prog_data,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              ovf
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_LDS  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_ADDS = 4'd4;
  localparam logic [3:0] OP_SUBI = 4'd5;
  localparam logic [3:0] OP_SUBS = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_JZ   = 4'd8;
  localparam logic [3:0] OP_JN   = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd10;

  logic [CW-1:0]     r_cnt;
  logic              r_s1;
  logic              r_s2;
  logic              r_sd;
  logic [DATA_W-1:0] r_acc;
  logic [ADDR_W-1:0] r_pc;
  logic              r_halted;
  logic              r_ovf;
  logic [DATA_W+3:0] r_mem [DEPTH];

  logic              w_tick;
  logic              w_rise;
  logic              w_ex;
  logic [DATA_W+3:0] w_instr;
  logic [3:0]        w_op;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_b;
  logic              w_sub;
  logic [DATA_W:0]   w_ext_a;
  logic [DATA_W:0]   w_ext_b;
  logic [DATA_W:0]   w_sum;
  logic              w_v;
  logic [DATA_W-1:0] w_acc_n;
  logic [ADDR_W-1:0] w_pc_n;
  logic              w_halt_n;
  logic              w_ovf_n;

  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge CLK_50 or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge CLK_50 or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_sd <= 1'b0;
    end else begin
      r_s1 <= step;
      r_s2 <= r_s1;
      r_sd <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_sd;
  assign w_ex   = (run ? w_tick : w_rise) & ~r_halted;

  // Memory has no reset so the program survives rst.
  always_ff @(posedge CLK_50) begin
    if (prog_we && !run) r_mem[prog_addr] <= prog_data;
  end

  assign w_instr = r_mem[r_pc];
  assign w_op    = w_instr[DATA_W+3:DATA_W];
  assign w_imm   = w_instr[DATA_W-1:0];

  assign w_b     = w_op[0] ? w_imm : in_chave;
  assign w_sub   = (w_op == OP_SUBI) || (w_op == OP_SUBS);
  assign w_ext_a = {r_acc[DATA_W-1], r_acc};
  assign w_ext_b = {w_b[DATA_W-1], w_b};
  assign w_sum   = w_sub ? (w_ext_a - w_ext_b) : (w_ext_a + w_ext_b);
  // Top two bits differ exactly when the truncated sign is wrong.
  assign w_v     = w_sum[DATA_W] ^ w_sum[DATA_W-1];

  always_comb begin
    w_acc_n  = r_acc;
    w_pc_n   = r_pc + 1'b1;
    w_halt_n = r_halted;
    w_ovf_n  = r_ovf;
    case (w_op)
      OP_LDI: begin
        w_acc_n = w_imm;
        w_ovf_n = 1'b0;
      end
      OP_LDS: begin
        w_acc_n = in_chave;
        w_ovf_n = 1'b0;
      end
      OP_ADDI, OP_ADDS, OP_SUBI, OP_SUBS: begin
        w_acc_n = w_sum[DATA_W-1:0];
        w_ovf_n = r_ovf | w_v;
      end
      OP_JMP: w_pc_n = w_imm[ADDR_W-1:0];
      OP_JZ: if (r_acc == '0) w_pc_n = w_imm[ADDR_W-1:0];
      OP_JN: if (r_acc[DATA_W-1]) w_pc_n = w_imm[ADDR_W-1:0];
      OP_HALT: begin
        w_pc_n   = r_pc;
        w_halt_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_50 or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_pc     <= '0;
      r_halted <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_ex) begin
      r_acc    <= w_acc_n;
      r_pc     <= w_pc_n;
      r_halted <= w_halt_n;
      r_ovf    <= w_ovf_n;
    end
  end

  assign acc_out = r_acc;
  assign pc_out  = r_pc;
  assign halted  = r_halted;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_processador_v3.sv
// Self-checking bench for processador_v3 (DATA_W=15, ADDR_W=4, TICK_DIV=4)
// with a behavioural instruction-level reference model.
module tb_processador_v3;

  localparam int DW = 15;
  localparam int AW = 4;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_chave = '0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW+3:0] prog_data = '0;
  logic [DW-1:0] acc_out;
  logic [AW-1:0] pc_out;
  logic          halted;
  logic          ovf;

  int n_chk = 0;
  int n_pass = 0;

  logic [DW+3:0] mem [16];
  int m_acc;
  int m_pc;
  bit m_halt;
  bit m_ovf;

  processador_v3 #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .TICK_DIV(TD)
  ) dut (
    .CLK_50(clk),
    .rst(rst),
    .in_chave(in_chave),
    .run(run),
    .step(step),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .acc_out(acc_out),
    .pc_out(pc_out),
    .halted(halted),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] ins(input int op, input int imm);
    logic [3:0] o;
    logic [14:0] i;
    o = 4'(op);
    i = 15'(imm);
    return {o, i};
  endfunction

  function automatic int sx(input logic [14:0] v);
    return int'($signed(v));
  endfunction

  function automatic int wrap15(input int v);
    int r;
    r = v & 32'h7fff;
    if (r > 16383) r = r - 32768;
    return r;
  endfunction

  task automatic model_exec();
    logic [18:0] w;
    int op, imm, x, full, nxt;
    if (m_halt) return;
    w   = mem[m_pc];
    op  = int'(w[18:15]);
    imm = sx(w[14:0]);
    nxt = (m_pc + 1) % 16;
    case (op)
      1: begin m_acc = imm; m_ovf = 0; end
      2: begin m_acc = sx(in_chave); m_ovf = 0; end
      3, 4, 5, 6: begin
        x = (op == 3 || op == 5) ? imm : sx(in_chave);
        full = (op < 5) ? m_acc + x : m_acc - x;
        if (full > 16383 || full < -16384) m_ovf = 1;
        m_acc = wrap15(full);
      end
      7: nxt = imm & 15;
      8: if (m_acc == 0) nxt = imm & 15;
      9: if (m_acc < 0) nxt = imm & 15;
      10: begin nxt = m_pc; m_halt = 1; end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic wr(input int a, input logic [18:0] d);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 4'(a);
    prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    mem[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0; m_pc = 0; m_halt = 0; m_ovf = 0;
  endtask

  task automatic do_step(input int hold);
    @(negedge clk);
    step = 1'b1;
    repeat (hold) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({acc_out, pc_out, halted, ovf} !== '0)
      $display("FAIL reset_state got acc=%0d pc=%0d h=%b o=%b exp all 0",
               acc_out, pc_out, halted, ovf);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_load_run();
    int chg_t[$];
    int chg_v[$];
    int prev;
    bit ok;
    do_reset();
    in_chave = 15'd2;
    wr(0, ins(1, 5));
    wr(1, ins(3, 3));
    wr(2, ins(6, 0));
    wr(3, ins(10, 0));
    @(negedge clk);
    run = 1'b1;
    prev = sx(acc_out);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sx(acc_out) != prev) begin
        chg_t.push_back(c);
        chg_v.push_back(sx(acc_out));
        prev = sx(acc_out);
      end
    end
    ok = (chg_v.size() == 3);
    if (ok) ok = (chg_v[0] == 5) && (chg_v[1] == 8) && (chg_v[2] == 6) &&
                 (chg_t[1] - chg_t[0] == TD) && (chg_t[2] - chg_t[1] == TD);
    n_chk++;
    if (!ok) $display("FAIL run_seq got %0d acc changes, last acc=%0d exp 5,8,6 every %0d",
                      chg_v.size(), sx(acc_out), TD);
    else n_pass++;
    n_chk++;
    if (halted !== 1'b1 || pc_out !== 4'd3)
      $display("FAIL run_halt got h=%b pc=%0d exp h=1 pc=3", halted, pc_out);
    else n_pass++;
    repeat (12) @(negedge clk);
    n_chk++;
    if (sx(acc_out) !== 6 || pc_out !== 4'd3 || halted !== 1'b1)
      $display("FAIL run_frozen got acc=%0d pc=%0d exp acc=6 pc=3", sx(acc_out), pc_out);
    else n_pass++;
    run = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
    wr(0, ins(1, 1));
    wr(1, ins(3, 1));
    wr(2, ins(3, 1));
    wr(3, ins(3, 1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      step = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if (pc_out !== 4'(k))
        $display("FAIL step_early got pc=%0d exp %0d", pc_out, k);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (pc_out !== 4'(k + 1))
        $display("FAIL step_land got pc=%0d exp %0d", pc_out, k + 1);
      else n_pass++;
      repeat (8) @(negedge clk);
      step = 1'b0;
      repeat (5) @(negedge clk);
      n_chk++;
      if (pc_out !== 4'(k + 1))
        $display("FAIL step_once got pc=%0d exp %0d", pc_out, k + 1);
      else n_pass++;
    end
    n_chk++;
    if (sx(acc_out) !== 3)
      $display("FAIL step_acc got %0d exp 3", sx(acc_out));
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    wr(0, ins(1, 16383));
    wr(1, ins(3, 1));
    wr(2, ins(0, 0));
    wr(3, ins(1, 0));
    do_step(1);
    do_step(1);
    n_chk++;
    if (sx(acc_out) !== -16384 || ovf !== 1'b1)
      $display("FAIL ovf_set got acc=%0d ovf=%b exp -16384 1", sx(acc_out), ovf);
    else n_pass++;
    do_step(1);
    n_chk++;
    if (ovf !== 1'b1 || sx(acc_out) !== -16384)
      $display("FAIL ovf_sticky got acc=%0d ovf=%b exp -16384 1", sx(acc_out), ovf);
    else n_pass++;
    do_step(1);
    n_chk++;
    if (ovf !== 1'b0 || sx(acc_out) !== 0)
      $display("FAIL ovf_clear got acc=%0d ovf=%b exp 0 0", sx(acc_out), ovf);
    else n_pass++;
  endtask

  task automatic test_branches();
    do_reset();
    wr(0, ins(1, 0));
    wr(1, ins(8, 5));
    do_step(1);
    do_step(1);
    n_chk++;
    if (pc_out !== 4'd5) $display("FAIL jz_taken got pc=%0d exp 5", pc_out);
    else n_pass++;
    do_reset();
    wr(0, ins(1, -1));
    wr(1, ins(9, 0));
    do_step(1);
    do_step(1);
    n_chk++;
    if (pc_out !== 4'd0) $display("FAIL jn_taken got pc=%0d exp 0", pc_out);
    else n_pass++;
    do_reset();
    wr(0, ins(1, 1));
    wr(1, ins(8, 5));
    do_step(1);
    do_step(1);
    n_chk++;
    if (pc_out !== 4'd2) $display("FAIL jz_not got pc=%0d exp 2", pc_out);
    else n_pass++;
    do_reset();
    wr(0, ins(7, 15));
    wr(15, ins(0, 0));
    do_step(1);
    n_chk++;
    if (pc_out !== 4'd15) $display("FAIL jmp15 got pc=%0d exp 15", pc_out);
    else n_pass++;
    do_step(1);
    n_chk++;
    if (pc_out !== 4'd0) $display("FAIL pc_wrap got pc=%0d exp 0", pc_out);
    else n_pass++;
  endtask

  task automatic test_write_gating();
    do_reset();
    wr(0, ins(10, 0));
    wr(2, ins(1, 7));
    @(negedge clk);
    run = 1'b1;
    repeat (8) @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 4'd2;
    prog_data = ins(1, 99);
    @(negedge clk);
    prog_we = 1'b0;
    run = 1'b0;
    do_reset();
    wr(0, ins(7, 2));
    do_step(1);
    do_step(1);
    n_chk++;
    if (sx(acc_out) !== 7 || pc_out !== 4'd3)
      $display("FAIL we_run_drop got acc=%0d pc=%0d exp 7 3", sx(acc_out), pc_out);
    else n_pass++;
    do_reset();
    wr(0, ins(1, 11));
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = ins(1, 22);
    @(negedge clk);
    prog_we = 1'b0;
    mem[0] = ins(1, 22);
    n_chk++;
    if (sx(acc_out) !== 11 || pc_out !== 4'd1)
      $display("FAIL we_coincide got acc=%0d pc=%0d exp 11 1", sx(acc_out), pc_out);
    else n_pass++;
    repeat (3) @(negedge clk);
    do_reset();
    do_step(1);
    n_chk++;
    if (sx(acc_out) !== 22)
      $display("FAIL we_new_word got acc=%0d exp 22", sx(acc_out));
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    in_chave = 15'd2;
    wr(0, ins(1, 5));
    wr(1, ins(3, 3));
    wr(2, ins(6, 0));
    wr(3, ins(10, 0));
    do_step(1);
    do_step(1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (acc_out !== '0 || pc_out !== '0 || halted !== 1'b0 || ovf !== 1'b0)
      $display("FAIL async_rst got acc=%0d pc=%0d exp 0 0", sx(acc_out), pc_out);
    else n_pass++;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (TD - 1) @(negedge clk);
    n_chk++;
    if (sx(acc_out) !== 0)
      $display("FAIL first_tick_early got acc=%0d exp 0", sx(acc_out));
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (sx(acc_out) !== 5 || pc_out !== 4'd1)
      $display("FAIL first_tick got acc=%0d pc=%0d exp 5 1", sx(acc_out), pc_out);
    else n_pass++;
    repeat (16) @(negedge clk);
    n_chk++;
    if (sx(acc_out) !== 6 || pc_out !== 4'd3 || halted !== 1'b1)
      $display("FAIL rst_rerun got acc=%0d pc=%0d h=%b exp 6 3 1",
               sx(acc_out), pc_out, halted);
    else n_pass++;
    run = 1'b0;
  endtask

  task automatic test_random();
    for (int p = 0; p < 3; p++) begin
      do_reset();
      for (int a = 0; a < 16; a++)
        wr(a, ins(int'($urandom_range(0, 15)), int'($urandom_range(0, 32767))));
      for (int s = 0; s < 30; s++) begin
        in_chave = 15'($urandom);
        do_step(1);
        model_exec();
        n_chk++;
        if (sx(acc_out) !== m_acc)
          $display("FAIL rand_acc got %0d exp %0d", sx(acc_out), m_acc);
        else n_pass++;
        n_chk++;
        if (int'(pc_out) !== m_pc)
          $display("FAIL rand_pc got %0d exp %0d", pc_out, m_pc);
        else n_pass++;
        n_chk++;
        if (ovf !== m_ovf)
          $display("FAIL rand_ovf got %b exp %b", ovf, m_ovf);
        else n_pass++;
        n_chk++;
        if (halted !== m_halt)
          $display("FAIL rand_halt got %b exp %b", halted, m_halt);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_step();
    test_overflow();
    test_branches();
    test_write_gating();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
